clk_monitor: RTL and testbench

CLK_MONITOR -- requirements
Module: clk_monitor

---
 rtl/clk_monitor_if.sv | 23 ++
 rtl/clk_monitor.sv | 113 +++++++++++
 tb/tb_clk_monitor.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/clk_monitor_if.sv
// rtl/clk_monitor_if.sv - external clock input and monitor result bundle
interface clk_monitor_if #(
    parameter int W = 7
);
    logic         extClk;
    logic         riseStrobe;
    logic         fallStrobe;
    logic [W-1:0] period;
    logic         periodValid;
    logic         periodUpdate;
    logic         clkLost;
    logic [1:0]   state;

    modport master (
        output extClk,
        input  riseStrobe, fallStrobe, period, periodValid, periodUpdate, clkLost, state
    );

    modport slave (
        input  extClk,
        output riseStrobe, fallStrobe, period, periodValid, periodUpdate, clkLost, state
    );
endinterface

// File: rtl/clk_monitor.sv
// rtl/clk_monitor.sv - measures the rise-to-rise period of an asynchronous clock and flags its loss
module clk_monitor #(
    parameter int inputFreq = 100_000_000,
    parameter int minFreq   = 1_000_000
) (
    input  logic         baseClk,
    input  logic         reset,
    clk_monitor_if.slave mon
);
    localparam int TIMEOUT = inputFreq / minFreq;
    localparam int W       = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] TIMEOUT_CNT = W'(TIMEOUT);
    localparam logic [W-1:0] ONE         = W'(1);

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2,
        LOST    = 2'd3
    } state_t;

    logic s1, s2, s3;
    logic rise_strobe_q, fall_strobe_q;
    logic [W-1:0] counter;
    logic [W-1:0] period_q;
    logic valid_q, update_q, lost_q;
    state_t state_q, state_d;
    logic load_period, valid_d, lost_d;

    // extClk is only ever sampled by s1; s3 holds the previous synchronized level
    always_ff @(posedge baseClk or posedge reset) begin
        if (reset) begin
            s1            <= 1'b0;
            s2            <= 1'b0;
            s3            <= 1'b0;
            rise_strobe_q <= 1'b0;
            fall_strobe_q <= 1'b0;
        end else begin
            s1            <= mon.extClk;
            s2            <= s1;
            s3            <= s2;
            rise_strobe_q <= s2 & ~s3;
            fall_strobe_q <= ~s2 & s3;
        end
    end

    always_ff @(posedge baseClk or posedge reset) begin
        if (reset) begin
            counter <= '0;
        end else if (rise_strobe_q) begin
            counter <= ONE;
        end else if (counter != TIMEOUT_CNT) begin
            counter <= counter + ONE;
        end
    end

    always_ff @(posedge baseClk or posedge reset) begin
        if (reset) begin
            state_q <= ACQUIRE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        load_period = 1'b0;
        valid_d     = valid_q;
        lost_d      = lost_q;
        case (state_q)
            ACQUIRE: if (rise_strobe_q) state_d = MEASURE;
            MEASURE: if (rise_strobe_q) begin
                state_d     = LOCKED;
                load_period = 1'b1;
                valid_d     = 1'b1;
            end
            LOCKED:  if (rise_strobe_q) load_period = 1'b1;
            LOST:    if (rise_strobe_q) begin
                state_d = MEASURE;
                lost_d  = 1'b0;
            end
            default: state_d = ACQUIRE;
        endcase
        // a rise landing on the timeout cycle still counts as a legal interval
        if (state_q != LOST && counter == TIMEOUT_CNT && !rise_strobe_q) begin
            state_d = LOST;
            lost_d  = 1'b1;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge baseClk or posedge reset) begin
        if (reset) begin
            period_q <= '0;
            valid_q  <= 1'b0;
            update_q <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            if (load_period) period_q <= counter;
            valid_q  <= valid_d;
            update_q <= load_period;
            lost_q   <= lost_d;
        end
    end

    assign mon.riseStrobe   = rise_strobe_q;
    assign mon.fallStrobe   = fall_strobe_q;
    assign mon.period       = period_q;
    assign mon.periodValid  = valid_q;
    assign mon.periodUpdate = update_q;
    assign mon.clkLost      = lost_q;
    assign mon.state        = state_q;
endmodule

// File: tb/tb_clk_monitor.sv
// tb/tb_clk_monitor.sv - directed self-checking bench for clk_monitor
module tb_clk_monitor;
    logic baseClk = 1'b0;
    logic reset   = 1'b1;

    clk_monitor_if #(.W(7)) mon ();

    clk_monitor dut (
        .baseClk (baseClk),
        .reset   (reset),
        .mon     (mon)
    );

    always #5 baseClk = ~baseClk;

    int total = 0;
    int bad   = 0;

    // cycle bookkeeping of DUT strobes, sampled on the falling edge
    int cyc = 0;
    int rise_cnt = 0, upd_cnt = 0;
    int last_rise = -1, last_fall = -1;
    int cnt7 = 0, cnt8 = 0, cnt_other = 0;

    always @(negedge baseClk) begin
        cyc = cyc + 1;
        if (mon.riseStrobe === 1'b1) begin
            rise_cnt  = rise_cnt + 1;
            last_rise = cyc;
        end
        if (mon.fallStrobe === 1'b1) last_fall = cyc;
        if (mon.periodUpdate === 1'b1) begin
            upd_cnt = upd_cnt + 1;
            if (mon.period == 7'd7) cnt7 = cnt7 + 1;
            else if (mon.period == 7'd8) cnt8 = cnt8 + 1;
            else cnt_other = cnt_other + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp)
        else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge baseClk);
        #1;
    endtask

    task automatic drive(input logic level, input int n);
        mon.extClk = level;
        repeat (n) tick();
    endtask

    int base;
    int r0, c7_0, c8_0, co_0;

    initial begin
        mon.extClk = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        check("rst_rise",   32'(mon.riseStrobe),   0);
        check("rst_fall",   32'(mon.fallStrobe),   0);
        check("rst_period", 32'(mon.period),       0);
        check("rst_valid",  32'(mon.periodValid),  0);
        check("rst_update", 32'(mon.periodUpdate), 0);
        check("rst_lost",   32'(mon.clkLost),      0);
        check("rst_state",  32'(mon.state),        0);

        reset = 1'b0;
        base  = cyc;

        // 10-cycle extClk, 30% duty
        drive(1'b1, 3);
        check("acq_rise",   32'(mon.riseStrobe), 1);
        check("acq_state",  32'(mon.state), 0);
        drive(1'b0, 7);
        check("meas_state", 32'(mon.state), 1);
        check("meas_valid", 32'(mon.periodValid), 0);
        check("first_fall", 32'(last_fall - base), 6);
        check("meas_noupd", 32'(upd_cnt), 0);
        drive(1'b1, 3);
        check("rise2",      32'(mon.riseStrobe), 1);
        check("rise2_noupd",32'(mon.periodUpdate), 0);
        drive(1'b0, 1);
        check("lock_upd",   32'(mon.periodUpdate), 1);
        check("lock_period",32'(mon.period), 10);
        check("lock_valid", 32'(mon.periodValid), 1);
        check("lock_state", 32'(mon.state), 2);
        drive(1'b0, 6);
        repeat (5) begin
            drive(1'b1, 3);
            drive(1'b0, 7);
        end
        check("run_rises",  32'(rise_cnt), 7);
        check("run_upds",   32'(upd_cnt), 6);
        check("run_lrise",  32'(last_rise - base), 63);
        check("run_lfall",  32'(last_fall - base), 66);
        check("run_period", 32'(mon.period), 10);

        // extClk stops: loss flagged once the counter saturates without a rise
        drive(1'b0, 93);
        check("prelost_lost",  32'(mon.clkLost), 0);
        check("prelost_state", 32'(mon.state), 2);
        drive(1'b0, 1);
        check("lost_lost",   32'(mon.clkLost), 1);
        check("lost_valid",  32'(mon.periodValid), 0);
        check("lost_state",  32'(mon.state), 3);
        check("lost_period", 32'(mon.period), 10);

        drive(1'b1, 3);
        check("relost_rise",  32'(mon.riseStrobe), 1);
        check("relost_state", 32'(mon.state), 3);
        drive(1'b0, 1);
        check("remeas_state", 32'(mon.state), 1);
        check("remeas_lost",  32'(mon.clkLost), 0);
        check("remeas_valid", 32'(mon.periodValid), 0);
        check("remeas_noupd", 32'(upd_cnt), 6);

        // interval of exactly TIMEOUT is legal
        drive(1'b0, 96);
        drive(1'b1, 3);
        check("t100_rise",  32'(mon.riseStrobe), 1);
        check("t100_lost",  32'(mon.clkLost), 0);
        drive(1'b0, 1);
        check("t100_period",32'(mon.period), 100);
        check("t100_valid", 32'(mon.periodValid), 1);
        check("t100_upd",   32'(mon.periodUpdate), 1);
        check("t100_state", 32'(mon.state), 2);
        check("t100_nolost",32'(mon.clkLost), 0);

        // interval of TIMEOUT+1 declares loss before the late rise
        drive(1'b0, 97);
        drive(1'b1, 3);
        check("t101_rise",  32'(mon.riseStrobe), 1);
        check("t101_lost",  32'(mon.clkLost), 1);
        check("t101_state", 32'(mon.state), 3);
        check("t101_valid", 32'(mon.periodValid), 0);
        check("t101_period",32'(mon.period), 100);
        drive(1'b0, 1);
        check("late_state", 32'(mon.state), 1);
        check("late_lost",  32'(mon.clkLost), 0);
        check("late_noupd", 32'(upd_cnt), 7);

        drive(1'b0, 6);
        drive(1'b1, 3);
        drive(1'b0, 1);
        check("relock_state", 32'(mon.state), 2);
        check("relock_period",32'(mon.period), 10);
        check("relock_upd",   32'(mon.periodUpdate), 1);
        drive(1'b0, 6);
        drive(1'b1, 3);
        drive(1'b0, 5);
        check("prerst_state", 32'(mon.state), 2);
        check("prerst_upds",  32'(upd_cnt), 9);

        // asynchronous reset mid-measurement
        #1 reset = 1'b1;
        #1;
        check("arst_period", 32'(mon.period), 0);
        check("arst_valid",  32'(mon.periodValid), 0);
        check("arst_state",  32'(mon.state), 0);
        check("arst_lost",   32'(mon.clkLost), 0);
        check("arst_flags",  32'({mon.riseStrobe, mon.fallStrobe, mon.periodUpdate}), 0);
        mon.extClk = 1'b1;
        tick();
        tick();
        check("arst_noupd",  32'(upd_cnt), 9);

        // extClk already high at release reports a rise three cycles later
        reset = 1'b0;
        base  = cyc;
        tick();
        tick();
        check("rel_norise",  32'(mon.riseStrobe), 0);
        tick();
        check("rel_rise",    32'(mon.riseStrobe), 1);
        check("rel_lrise",   32'(last_rise - base), 3);
        check("rel_state",   32'(mon.state), 0);
        drive(1'b1, 3);
        drive(1'b0, 6);
        drive(1'b1, 3);
        check("p12_state",   32'(mon.state), 1);
        drive(1'b0, 1);
        check("p12_period",  32'(mon.period), 12);
        check("p12_valid",   32'(mon.periodValid), 1);
        check("p12_upd",     32'(mon.periodUpdate), 1);
        check("p12_state2",  32'(mon.state), 2);
        check("p12_upds",    32'(upd_cnt), 10);

        // non-integer ratio: 7.3 baseClk cycles per extClk period
        mon.extClk = 1'b1;
        #37 mon.extClk = 1'b0;
        #36;
        r0   = rise_cnt;
        c7_0 = cnt7;
        c8_0 = cnt8;
        co_0 = cnt_other;
        repeat (29) begin
            mon.extClk = 1'b1;
            #37 mon.extClk = 1'b0;
            #36;
        end
        repeat (6) tick();
        check("frac_rises",  32'(rise_cnt - r0), 29);
        check("frac_other",  32'(cnt_other - co_0), 0);
        check("frac_has7",   32'((cnt7 - c7_0) > 0), 1);
        check("frac_has8",   32'((cnt8 - c8_0) > 0), 1);
        check("frac_sum",    32'((cnt7 - c7_0) + (cnt8 - c8_0)), 29);
        check("frac_state",  32'(mon.state), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
